// File: rtl/arb_pkg.sv
// arb_pkg -- shared types and constants for the memory port arbiter.
//   arb_state_t : arbiter FSM states (idle / waiting on a RAM read)
//   arb_owner_t : which requester owns the outstanding read
//   ARB_OP_STR  : STR opcode, decoded by the memory stage into mem_we
//   sat_inc16   : saturating 16-bit increment used by the stall counters
package arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_READ_WAIT} arb_state_t;
   typedef enum logic {OWN_FETCH, OWN_MEM} arb_owner_t;

   localparam logic [3:0] ARB_OP_STR = 4'b0101;

   function automatic logic [15:0] sat_inc16(input logic [15:0] cnt, input logic en);
      if (en && (cnt != 16'hFFFF)) begin
         return cnt + 16'd1;
      end
      return cnt;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if -- bundle of the fetch, memory-stage and RAM signals
// around the arbiter.
//   slave  : arbiter view (takes requests and ram_rdata, drives grants,
//            return data, RAM strobes and stalls)
//   master : environment view (pipeline stages plus RAM macro)
interface mem_port_arbiter_if;

   // instruction fetch port (read only)
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [15:0] if_rdata;

   // memory-stage port (LDR/STR)
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;

   // RAM macro side
   logic        ram_en;
   logic        ram_we;
   logic [15:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;

   // pipeline stalls
   logic        stall_fetch;
   logic        stall_mem;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      output if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
             ram_en, ram_we, ram_addr, ram_wdata, stall_fetch, stall_mem
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      input  if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
             ram_en, ram_we, ram_addr, ram_wdata, stall_fetch, stall_mem
   );

endinterface

// File: rtl/arb_lat_tracker.sv
// arb_lat_tracker -- read-latency counter and return routing for the arbiter.
//   clk, reset_n : clock / asynchronous active-low reset
//   in_wait      : arbiter is in READ_WAIT
//   start        : a read is granted this cycle (owner taken from start_owner)
//   ram_rdata    : RAM read data
//   last_cycle   : final READ_WAIT cycle, data present on ram_rdata
//   owner        : requester owning the outstanding read
//   if_/mem_rvalid, if_/mem_rdata : per-requester return channels
module arb_lat_tracker
   import arb_pkg::*;
#(
   parameter int RAM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_wait,
   input  logic        start,
   input  arb_owner_t  start_owner,
   input  logic [15:0] ram_rdata,
   output logic        last_cycle,
   output arb_owner_t  owner,
   output logic        if_rvalid,
   output logic [15:0] if_rdata,
   output logic        mem_rvalid,
   output logic [15:0] mem_rdata
);

   localparam int CW = 3;
   localparam logic [CW-1:0] LAT_LAST = CW'(RAM_LATENCY - 1);

   logic [CW-1:0] lat_cnt_reg;
   arb_owner_t    owner_reg;
   logic [1:0]    rvalid;
   logic [15:0]   rdata_out [2];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lat_cnt_reg <= '0;
         owner_reg   <= OWN_FETCH;
      end else if (start) begin
         lat_cnt_reg <= '0;
         owner_reg   <= start_owner;
      end else if (in_wait && !last_cycle) begin
         lat_cnt_reg <= lat_cnt_reg + 1'b1;
      end
   end

   assign last_cycle = in_wait && (lat_cnt_reg == LAT_LAST);
   assign owner      = owner_reg;

   // Channel 0 returns to fetch, channel 1 to the memory stage. The data is
   // passed straight from the RAM in the rvalid cycle and held afterwards, so
   // the non-owner keeps its last delivered word.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ret
         logic [15:0] hold_reg;

         assign rvalid[gi] = last_cycle && (owner_reg == ((gi == 0) ? OWN_FETCH : OWN_MEM));

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               hold_reg <= '0;
            end else if (rvalid[gi]) begin
               hold_reg <= ram_rdata;
            end
         end

         assign rdata_out[gi] = rvalid[gi] ? ram_rdata : hold_reg;
      end
   endgenerate

   assign if_rvalid  = rvalid[0];
   assign if_rdata   = rdata_out[0];
   assign mem_rvalid = rvalid[1];
   assign mem_rdata  = rdata_out[1];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter -- shares one single-port RAM between instruction fetch
// and the memory stage. Memory stage has priority; after MAX_DATA_STREAK
// consecutive wins against a waiting fetch, fetch is forced through.
//   clk, reset_n : clock / asynchronous active-low reset
//   bus          : mem_port_arbiter_if.slave (requests, grants, return data,
//                  RAM strobes, stalls)
// Optional (macro ARB_PERF_CNT_EN):
//   perf_clr         : synchronous clear of both stall counters
//   perf_fetch_stall : saturating count of stall_fetch cycles
//   perf_mem_stall   : saturating count of stall_mem cycles
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int RAM_LATENCY     = 1,
   parameter int MAX_DATA_STREAK = 3
) (
   input  logic clk,
   input  logic reset_n,
   mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
   ,
   input  logic        perf_clr,
   output logic [15:0] perf_fetch_stall,
   output logic [15:0] perf_mem_stall
`endif
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

   arb_state_t state_reg;
   logic [3:0] streak_reg;
   logic [3:0] streak_next;
   logic       grant_ok;
   logic       grant_if;
   logic       grant_mem;
   logic       read_start;
   logic       in_wait;
   logic       last_cycle;
   arb_owner_t owner;

   assign in_wait = (state_reg == ARB_READ_WAIT);

   // Grants are suppressed while reset is held so every output reads 0.
   assign grant_ok = reset_n && ((state_reg == ARB_IDLE) || last_cycle);

   always_comb begin
      grant_if    = 1'b0;
      grant_mem   = 1'b0;
      streak_next = streak_reg;
      if (grant_ok) begin
         if (bus.if_req && bus.mem_req) begin
            if (streak_reg >= STREAK_MAX) begin
               grant_if    = 1'b1;
               streak_next = '0;
            end else begin
               grant_mem   = 1'b1;
               streak_next = streak_reg + 4'd1;
            end
         end else if (bus.mem_req) begin
            grant_mem = 1'b1;
         end else if (bus.if_req) begin
            grant_if    = 1'b1;
            streak_next = '0;
         end
      end
   end

   assign read_start = grant_if || (grant_mem && !bus.mem_we);

   // Writes finish in the grant cycle, so only reads enter READ_WAIT; a
   // final wait cycle without a new read falls back to IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= ARB_IDLE;
         streak_reg <= '0;
      end else begin
         streak_reg <= streak_next;
         if (read_start) begin
            state_reg <= ARB_READ_WAIT;
         end else if (grant_ok) begin
            state_reg <= ARB_IDLE;
         end
      end
   end

   arb_lat_tracker #(
      .RAM_LATENCY (RAM_LATENCY)
   ) u_lat (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_wait     (in_wait),
      .start       (read_start),
      .start_owner (grant_mem ? OWN_MEM : OWN_FETCH),
      .ram_rdata   (bus.ram_rdata),
      .last_cycle  (last_cycle),
      .owner       (owner),
      .if_rvalid   (bus.if_rvalid),
      .if_rdata    (bus.if_rdata),
      .mem_rvalid  (bus.mem_rvalid),
      .mem_rdata   (bus.mem_rdata)
   );

   assign bus.if_gnt    = grant_if;
   assign bus.mem_gnt   = grant_mem;
   assign bus.ram_en    = grant_if || grant_mem;
   assign bus.ram_we    = grant_mem && bus.mem_we;
   assign bus.ram_addr  = grant_mem ? bus.mem_addr : (grant_if ? bus.if_addr : 16'h0);
   assign bus.ram_wdata = grant_mem ? bus.mem_wdata : 16'h0;

   assign bus.stall_fetch = reset_n && bus.if_req && !grant_if;
   assign bus.stall_mem   = reset_n && ((bus.mem_req && !grant_mem) ||
                                        (in_wait && (owner == OWN_MEM) && !bus.mem_rvalid));

`ifdef ARB_PERF_CNT_EN
   logic [15:0] perf_fetch_reg;
   logic [15:0] perf_mem_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetch_reg <= '0;
         perf_mem_reg   <= '0;
      end else if (perf_clr) begin
         perf_fetch_reg <= '0;
         perf_mem_reg   <= '0;
      end else begin
         perf_fetch_reg <= sat_inc16(perf_fetch_reg, bus.stall_fetch);
         perf_mem_reg   <= sat_inc16(perf_mem_reg, bus.stall_mem);
      end
   end

   assign perf_fetch_stall = perf_fetch_reg;
   assign perf_mem_stall   = perf_mem_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter -- directed bench for mem_port_arbiter.
// u2: RAM_LATENCY=2 (reset, lone fetch, store, back-to-back loads, perf)
// u1: RAM_LATENCY=1 (contention / starvation sequence)
// Optional macro ARB_PERF_CNT_EN enables the stall-counter checks.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if b1();
   mem_port_arbiter_if b2();

`ifdef ARB_PERF_CNT_EN
   logic        perf_clr;
   logic [15:0] pf1, pm1, pf2, pm2;
`endif

   mem_port_arbiter #(.RAM_LATENCY(1), .MAX_DATA_STREAK(3)) u1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b1)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_clr         (perf_clr),
      .perf_fetch_stall (pf1),
      .perf_mem_stall   (pm1)
`endif
   );

   mem_port_arbiter #(.RAM_LATENCY(2), .MAX_DATA_STREAK(3)) u2 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (b2)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_clr         (perf_clr),
      .perf_fetch_stall (pf2),
      .perf_mem_stall   (pm2)
`endif
   );

   // RAM contents seen by u2
   function automatic logic [15:0] rom(input logic [15:0] a);
      case (a)
         16'h0004: return 16'hBEEF;
         16'h0010: return 16'hAAAA;
         16'h0020: return 16'h1111;
         16'h0022: return 16'h2222;
         default:  return {8'hD0, a[7:0]};
      endcase
   endfunction

   // RAM models: u2 two-stage read pipe, u1 one-stage; u2 writes captured.
   logic [15:0] r2_s1 = '0;
   logic [15:0] r2_s2 = '0;
   logic [15:0] r1_s1 = '0;
   logic [15:0] wr_addr = '0;
   logic [15:0] wr_data = '0;

   always @(posedge clk) begin
      r2_s1 <= (b2.ram_en && !b2.ram_we) ? rom(b2.ram_addr) : 16'h0;
      r2_s2 <= r2_s1;
      r1_s1 <= b1.ram_en ? {8'hC1, b1.ram_addr[7:0]} : 16'h0;
      if (b2.ram_en && b2.ram_we) begin
         wr_addr <= b2.ram_addr;
         wr_data <= b2.ram_wdata;
      end
   end

   assign b2.ram_rdata = r2_s2;
   assign b1.ram_rdata = r1_s1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   logic [7:0] pat;

   initial begin
      reset_n = 1'b0;
      b1.if_req = 1'b0; b1.if_addr = '0; b1.mem_req = 1'b0; b1.mem_we = 1'b0;
      b1.mem_addr = '0; b1.mem_wdata = '0;
      b2.if_req = 1'b1; b2.if_addr = 16'h0010; b2.mem_req = 1'b0; b2.mem_we = 1'b0;
      b2.mem_addr = '0; b2.mem_wdata = '0;
`ifdef ARB_PERF_CNT_EN
      perf_clr = 1'b0;
`endif

      // reset state, with a fetch request held during reset
      repeat (2) nxt();
      mid();
      $display("txn reset_hold");
      check("rst_if_gnt",   32'(b2.if_gnt), 32'd0);
      check("rst_ram_en",   32'(b2.ram_en), 32'd0);
      check("rst_stall_f",  32'(b2.stall_fetch), 32'd0);
      check("rst_if_rdata", 32'(b2.if_rdata), 32'd0);
      check("rst_mem_rdata",32'(b2.mem_rdata), 32'd0);
      nxt();
      reset_n = 1'b1;

      // reset mid-read: fetch 0x0010 granted, then reset
      mid();
      $display("txn fetch_then_reset addr=0010");
      check("mr_if_gnt", 32'(b2.if_gnt), 32'd1);
      nxt();
      reset_n = 1'b0; b2.if_req = 1'b0;
      mid();
      check("mr_rvalid_c1", 32'(b2.if_rvalid), 32'd0);
      nxt();
      mid();
      check("mr_rvalid_c2", 32'(b2.if_rvalid), 32'd0);
      nxt();
      reset_n = 1'b1;
      mid();
      check("mr_rvalid_c3", 32'(b2.if_rvalid), 32'd0);
      check("mr_if_rdata",  32'(b2.if_rdata), 32'd0);
      check("mr_ram_en",    32'(b2.ram_en), 32'd0);
      nxt();

      // lone fetch 0x0004 -> BEEF at cycle 2
      b2.if_req = 1'b1; b2.if_addr = 16'h0004;
      mid();
      $display("txn lone_fetch addr=0004");
      check("lf_if_gnt",  32'(b2.if_gnt), 32'd1);
      check("lf_ram_en",  32'(b2.ram_en), 32'd1);
      check("lf_ram_we",  32'(b2.ram_we), 32'd0);
      check("lf_ram_addr",32'(b2.ram_addr), 32'h0004);
      check("lf_stall_f", 32'(b2.stall_fetch), 32'd0);
      nxt();
      b2.if_req = 1'b0;
      mid();
      check("lf_rvalid_c1", 32'(b2.if_rvalid), 32'd0);
      nxt();
      mid();
      check("lf_rvalid_c2", 32'(b2.if_rvalid), 32'd1);
      check("lf_rdata_c2",  32'(b2.if_rdata), 32'hBEEF);
      check("lf_mrvalid_c2",32'(b2.mem_rvalid), 32'd0);
      nxt();
      mid();
      check("lf_rvalid_c3", 32'(b2.if_rvalid), 32'd0);
      check("lf_rdata_hold",32'(b2.if_rdata), 32'hBEEF);
      check("lf_mem_rdata", 32'(b2.mem_rdata), 32'd0);
      nxt();

      // store 0x1234 to 0x0100, fetch granted next cycle
      b2.mem_req = 1'b1; b2.mem_we = 1'b1; b2.mem_addr = 16'h0100; b2.mem_wdata = 16'h1234;
      mid();
      $display("txn store addr=0100 data=1234");
      check("st_mem_gnt",  32'(b2.mem_gnt), 32'd1);
      check("st_ram_we",   32'(b2.ram_we), 32'd1);
      check("st_ram_addr", 32'(b2.ram_addr), 32'h0100);
      check("st_ram_wdata",32'(b2.ram_wdata), 32'h1234);
      nxt();
      b2.mem_req = 1'b0; b2.mem_we = 1'b0;
      b2.if_req = 1'b1; b2.if_addr = 16'h0004;
      mid();
      check("st_wr_addr",   32'(wr_addr), 32'h0100);
      check("st_wr_data",   32'(wr_data), 32'h1234);
      check("st_next_ifgnt",32'(b2.if_gnt), 32'd1);
      check("st_mrvalid",   32'(b2.mem_rvalid), 32'd0);
      nxt();
      b2.if_req = 1'b0;
      mid();
      check("st_mrvalid_c2",32'(b2.mem_rvalid), 32'd0);
      nxt();
      mid();
      check("st_if_rvalid", 32'(b2.if_rvalid), 32'd1);
      nxt();

      // back-to-back loads 0x0020, 0x0022
      b2.mem_req = 1'b1; b2.mem_we = 1'b0; b2.mem_addr = 16'h0020;
      mid();
      $display("txn load addr=0020");
      check("bb_gnt_c0",  32'(b2.mem_gnt), 32'd1);
      check("bb_addr_c0", 32'(b2.ram_addr), 32'h0020);
      nxt();
      b2.mem_addr = 16'h0022;
      mid();
      check("bb_gnt_c1",   32'(b2.mem_gnt), 32'd0);
      check("bb_stall_c1", 32'(b2.stall_mem), 32'd1);
      nxt();
      mid();
      $display("txn load addr=0022");
      check("bb_gnt_c2",    32'(b2.mem_gnt), 32'd1);
      check("bb_addr_c2",   32'(b2.ram_addr), 32'h0022);
      check("bb_rvalid_c2", 32'(b2.mem_rvalid), 32'd1);
      check("bb_rdata_c2",  32'(b2.mem_rdata), 32'h1111);
      check("bb_ifrv_c2",   32'(b2.if_rvalid), 32'd0);
      nxt();
      b2.mem_req = 1'b0;
      mid();
      check("bb_rvalid_c3", 32'(b2.mem_rvalid), 32'd0);
      check("bb_stall_c3",  32'(b2.stall_mem), 32'd1);
      nxt();
      mid();
      check("bb_rvalid_c4", 32'(b2.mem_rvalid), 32'd1);
      check("bb_rdata_c4",  32'(b2.mem_rdata), 32'h2222);
      check("bb_stall_c4",  32'(b2.stall_mem), 32'd0);
      check("bb_ifrv_c4",   32'(b2.if_rvalid), 32'd0);
      nxt();

      // contention on u1 (latency 1): M M M F M M M F
      pat = 8'b0111_0111;
      b1.if_req = 1'b1; b1.if_addr = 16'h0040;
      b1.mem_req = 1'b1; b1.mem_we = 1'b0; b1.mem_addr = 16'h0080;
      for (int k = 0; k <= 8; k++) begin
         if (k == 8) begin
            b1.if_req = 1'b0; b1.mem_req = 1'b0;
         end
         mid();
         if (k < 8) begin
            $display("txn contention cycle=%0d expect=%s", k, pat[k] ? "mem" : "fetch");
            check($sformatf("ct_mem_gnt_%0d", k), 32'(b1.mem_gnt), 32'(pat[k]));
            check($sformatf("ct_if_gnt_%0d", k),  32'(b1.if_gnt), 32'(!pat[k]));
            check($sformatf("ct_stall_f_%0d", k), 32'(b1.stall_fetch), 32'(pat[k]));
         end else begin
            check("ct_no_gnt", 32'(b1.mem_gnt | b1.if_gnt), 32'd0);
         end
         if (k >= 1) begin
            check($sformatf("ct_mrv_%0d", k), 32'(b1.mem_rvalid), 32'(pat[k-1]));
            check($sformatf("ct_irv_%0d", k), 32'(b1.if_rvalid), 32'(!pat[k-1]));
            if (pat[k-1])
               check($sformatf("ct_mrd_%0d", k), 32'(b1.mem_rdata), 32'hC180);
            else
               check($sformatf("ct_ird_%0d", k), 32'(b1.if_rdata), 32'hC140);
         end
         nxt();
      end

`ifdef ARB_PERF_CNT_EN
      // perf counters on u2: clear, then 5 fetch-stall cycles
      perf_clr = 1'b1;
      nxt();
      perf_clr = 1'b0;
      b2.if_req = 1'b1; b2.if_addr = 16'h0004;
      b2.mem_req = 1'b1; b2.mem_we = 1'b0; b2.mem_addr = 16'h0020;
      mid();
      $display("txn perf_stall");
      check("pf_after_clr", 32'(pf2), 32'd0);
      check("pm_after_clr", 32'(pm2), 32'd0);
      nxt();
      repeat (4) nxt();
      b2.if_req = 1'b0; b2.mem_req = 1'b0;
      mid();
      check("pf_count5", 32'(pf2), 32'd5);
      check("pm_count2", 32'(pm2), 32'd2);
      nxt();
      perf_clr = 1'b1;
      nxt();
      perf_clr = 1'b0;
      mid();
      $display("txn perf_clr");
      check("pf_cleared", 32'(pf2), 32'd0);
      check("pm_cleared", 32'(pm2), 32'd0);
      nxt();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 16-bit data/instruction RAM between instruction fetch (read-only) and the memory stage (LDR/STR).
- Sits between the fetch and memory pipeline stages and the RAM macro.
- Owns request/grant, read-latency tracking and return routing.
- Fixed priority to the memory stage, with an anti-starvation counter that guarantees fetch progress.

Parameters:
- RAM_LATENCY, 1, cycles from RAM enable to valid ram_rdata; legal range 1..4.
- MAX_DATA_STREAK, 3, consecutive memory-stage wins against a waiting fetch before fetch is forced through; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  16  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  16  fetched instruction word
- mem_req  in  1  memory-stage request; held until mem_gnt
- mem_we  in  1  1 = STR, 0 = LDR
- mem_addr  in  16  load/store address (already forwarded)
- mem_wdata  in  16  store data
- mem_gnt  out  1  memory-stage request accepted this cycle
- mem_rvalid  out  1  one-cycle pulse, mem_rdata valid (loads only)
- mem_rdata  out  16  load data
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  16  RAM address
- ram_wdata  out  16  RAM write data
- ram_rdata  in  16  RAM read data
- stall_fetch  out  1  if_req pending and not granted this cycle
- stall_mem  out  1  mem_req pending and not granted, or own load outstanding without mem_rvalid

Behaviour:
- FSM states: IDLE, READ_WAIT.
  - Registers: owner (FETCH/MEM), lat_cnt, streak_cnt.
- Reset values (async assert, sync-free):
  - State IDLE, lat_cnt 0, streak_cnt 0.
  - All out ports 0, including rdata buses.
- Grants are combinational from state and requests; ram_en/ram_we/ram_addr/ram_wdata are driven in the grant cycle from the granted requester.
- IDLE, or READ_WAIT in its final cycle (lat_cnt == RAM_LATENCY-1), may grant. Arbitration in that cycle:
  - Only one requester: grant it.
  - Both requesting, streak_cnt < MAX_DATA_STREAK: grant mem; streak_cnt += 1.
  - Both requesting, streak_cnt == MAX_DATA_STREAK: grant fetch; streak_cnt = 0.
  - Any fetch grant clears streak_cnt. Mem grant with if_req low leaves streak_cnt unchanged.
- Granted write (mem_we=1):
  - Completes in the grant cycle; stays in or returns to IDLE.
  - No rvalid.
  - Next cycle may grant again.
- Granted read:
  - Go to READ_WAIT; owner latched; lat_cnt = 0, then increments each cycle.
  - Read data returned RAM_LATENCY cycles after grant: rvalid to owner for one cycle, rdata = ram_rdata (registered through the output).
  - The rvalid cycle is also a legal grant cycle, so back-to-back reads sustain 1 access per RAM_LATENCY cycles.
- The non-owner's rvalid and rdata hold 0/previous value; rdata only updates on the owner's rvalid.
- Request/address changes while not granted are permitted; the arbiter samples only in grant cycles.
- Reset asserted mid-read: the transaction is dropped, no rvalid is issued, and the state returns to IDLE.
- Address arithmetic: none. Addresses pass through unmodified; wrap is the RAM's concern.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_stall[15:0] and perf_mem_stall[15:0].
  - Each counts cycles with the matching stall_* high.
  - Saturates at 16'hFFFF; cleared by reset_n.
  - Input perf_clr (1 bit) clears both counters synchronously; perf_clr wins over increment.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package (arb_pkg) holds:
  - typedef enum {ARB_IDLE, ARB_READ_WAIT} arb_state_t;
  - typedef enum {OWN_FETCH, OWN_MEM} arb_owner_t;
  - Constant for the STR opcode 4'b0101, consumed by the memory stage when driving mem_we.
- One natural sub-module: arb_lat_tracker, holding lat_cnt, owner and the rvalid/rdata return registers. The top keeps the FSM, priority and streak logic.

Test Plan:
- Reset mid-read: RAM_LATENCY=2, fetch read 16'h0010 granted, reset_n low next cycle -> no if_rvalid ever; after release, outputs 0 and state IDLE.
- Lone fetch: if_req, if_addr=16'h0004, RAM returns 16'hBEEF -> if_gnt cycle 0 with ram_en=1, ram_addr=16'h0004; if_rvalid=1, if_rdata=16'hBEEF at cycle RAM_LATENCY.
- Store: mem_req, mem_we=1, addr 16'h0100, wdata 16'h1234 -> mem_gnt, ram_we=1 same cycle; no mem_rvalid; fetch grantable next cycle.
- Contention with starvation: both requesting continuously, MAX_DATA_STREAK=3, RAM_LATENCY=1, all loads -> grant sequence mem, mem, mem, fetch, mem, mem, mem, fetch...; stall_fetch high on every mem grant cycle.
- Back-to-back loads: RAM_LATENCY=2, mem loads to 16'h0020 then 16'h0022 -> grants at cycles 0 and 2; mem_rvalid at cycles 2 and 4 with the correct data; no fetch rvalid.
- Perf counters: ARB_PERF_CNT_EN defined, 5 fetch-stall cycles -> perf_fetch_stall=5; perf_clr pulse -> 0.
